stopwatch_lap_ctrl: RTL
=======================

// Module: stopwatch_lap_ctrl
// PURPOSE
//   Parametrised stopwatch controller with lap memory. Replaces the fixed
//   one-hot control FSM. Acts on button releases, drives the time counter's
//   enable/clear, and stores lap times in a circular buffer of LAP_DEPTH
//   entries. The display mux can show the live time or a stored lap.
// PARAMETERS
//   TIME_W     24  width of time_in, display and each lap entry
//   LAP_DEPTH   8  lap buffer entries; power of 2, >=2
//   PTR_W      local = $clog2(LAP_DEPTH)
// PORTS
//   clock        in   1         system clock; all logic on posedge
//   reset        in   1         asynchronous, active-high; clears all state
//   stimulus     in   4         [3]=start_pause [2]=lap [1]=zero [0]=clear; level, 1=pressed
//   time_in      in   TIME_W    running time from the external counter
//   count_en     out  1         counter run enable
//   count_clr    out  1         1-cycle pulse: zero the counter
//   display      out  TIME_W    registered; time_in, or lap[lap_idx] when showing_lap=1
//   showing_lap  out  1         1 while in RETRIEVE
//   lap_idx      out  PTR_W     buffer index being displayed
//   lap_count    out  PTR_W+1   valid laps stored, saturates at LAP_DEPTH
//   state        out  2         IDLE=0 RUN=1 PAUSE=2 RETRIEVE=3
// BEHAVIOUR
// - Reset values: state=IDLE, btn_q=0, wr_ptr=0, lap_idx=0, lap_count=0.
//   All outputs 0. Buffer RAM is not cleared.
// - Button event: rel[i] = btn_q[i] & ~stimulus[i], where btn_q is stimulus
//   registered. Every action fires on the edge that samples the release and is
//   visible on the next cycle. A button held through reset yields a release
//   event when it is let go.
// - Simultaneous releases are handled by priority: clear > zero > start_pause > lap.
//   Only the winning event acts; the others are dropped.
// - IDLE: count_en=0. start_pause -> RUN. clear -> wr_ptr=0, lap_count=0.
//   zero/lap ignored.
// - RUN: count_en=1.
//   - start_pause -> PAUSE.
//   - lap -> buf[wr_ptr]<=time_in (value sampled at the release edge);
//     wr_ptr++ mod LAP_DEPTH; lap_count++ saturating.
//   - When full, the oldest lap is overwritten.
//   - zero/clear ignored.
// - PAUSE: count_en=0.
//   - start_pause -> RUN.
//   - zero -> count_clr=1 for exactly 1 cycle, then IDLE; laps are kept.
//   - clear -> wr_ptr=0, lap_count=0; stay in PAUSE.
//   - lap -> if lap_count>0: RETRIEVE with lap_idx=wr_ptr-1 (newest); else ignored.
// - RETRIEVE: count_en=0, showing_lap=1.
//   - lap -> step lap_idx to the next older entry. After the oldest entry
//     (index wr_ptr-lap_count mod LAP_DEPTH) it wraps to the newest.
//   - start_pause -> PAUSE (view exits; the counter does not resume).
//   - zero -> count_clr pulse, then IDLE.
//   - clear -> laps cleared, then PAUSE.
// - display: registered, 1-cycle latency from time_in or lap_idx.
//   Shows time_in whenever showing_lap=0.
// - Async reset asserted mid-operation: all state returns to reset values
//   immediately. A pending count_clr is cancelled.
// TESTING
// 1. Reset, then press/release start_pause -> state=1 and count_en=1 on the
//    cycle after the release.
// 2. In RUN, lap released with time_in=0x000123, then 0x000456 ->
//    lap_count=2, wr_ptr=2, entries 0/1 hold 0x123/0x456.
// 3. Record 10 laps (values 1..10) with LAP_DEPTH=8 -> lap_count=8; a
//    retrieve walk in PAUSE shows 10,9,...,3 then wraps to 10.
// 4. Release start_pause and lap on the same cycle in RUN -> PAUSE only;
//    lap_count unchanged.
// 5. In PAUSE release zero -> count_clr high exactly 1 cycle, state=0, laps
//    retained. Then release clear in IDLE -> lap_count=0.
// 6. Assert reset while in RETRIEVE with 3 laps -> all outputs 0 asynchronously.
//    After deassert, a lap release in PAUSE is ignored (lap_count=0).

Source files
------------

// File: rtl/stopwatch_lap_ctrl.sv
`default_nettype none
// stopwatch_lap_ctrl: stopwatch control FSM that acts on button releases
// and stores lap times in a circular buffer for later review.
module stopwatch_lap_ctrl #(
  parameter int TIME_W    = 24,
  parameter int LAP_DEPTH = 8,
  localparam int PTR_W    = $clog2(LAP_DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [3:0]        stimulus,
  input  logic [TIME_W-1:0] time_in,
  output logic              count_en,
  output logic              count_clr,
  output logic [TIME_W-1:0] display,
  output logic              showing_lap,
  output logic [PTR_W-1:0]  lap_idx,
  output logic [PTR_W:0]    lap_count,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_PAUSE    = 2'd2,
    S_RETRIEVE = 2'd3
  } state_t;

  localparam logic [PTR_W:0] LAP_FULL = (PTR_W+1)'(LAP_DEPTH);

  state_t             state_q, state_d;
  logic [3:0]         btn_q;
  logic [3:0]         rel;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   lap_idx_q, lap_idx_d;
  logic [PTR_W:0]     lap_count_q, lap_count_d;
  logic               count_clr_q, count_clr_d;
  logic               lap_we;
  logic [PTR_W-1:0]   newest, oldest;
  logic               ev_clear, ev_zero, ev_sp, ev_lap;
  logic [TIME_W-1:0]  display_q;
  logic [TIME_W-1:0]  lap_mem [LAP_DEPTH];

  assign rel = btn_q & ~stimulus;

  // One winning event per cycle: clear > zero > start_pause > lap
  assign ev_clear = rel[0];
  assign ev_zero  = rel[1] & ~rel[0];
  assign ev_sp    = rel[3] & ~rel[1] & ~rel[0];
  assign ev_lap   = rel[2] & ~rel[3] & ~rel[1] & ~rel[0];

  assign newest = wr_ptr_q - 1'b1;
  assign oldest = wr_ptr_q - lap_count_q[PTR_W-1:0];

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    lap_idx_d   = lap_idx_q;
    lap_count_d = lap_count_q;
    count_clr_d = 1'b0;
    lap_we      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ev_sp) begin
          state_d = S_RUN;
        end else if (ev_clear) begin
          wr_ptr_d    = '0;
          lap_count_d = '0;
        end
      end
      S_RUN: begin
        if (ev_sp) begin
          state_d = S_PAUSE;
        end else if (ev_lap) begin
          lap_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (lap_count_q != LAP_FULL) lap_count_d = lap_count_q + 1'b1;
        end
      end
      S_PAUSE: begin
        if (ev_sp) begin
          state_d = S_RUN;
        end else if (ev_zero) begin
          count_clr_d = 1'b1;
          state_d     = S_IDLE;
        end else if (ev_clear) begin
          wr_ptr_d    = '0;
          lap_count_d = '0;
        end else if (ev_lap && (lap_count_q != '0)) begin
          state_d   = S_RETRIEVE;
          lap_idx_d = newest;
        end
      end
      S_RETRIEVE: begin
        if (ev_sp) begin
          state_d = S_PAUSE;
        end else if (ev_zero) begin
          count_clr_d = 1'b1;
          state_d     = S_IDLE;
        end else if (ev_clear) begin
          wr_ptr_d    = '0;
          lap_count_d = '0;
          lap_idx_d   = '0;
          state_d     = S_PAUSE;
        end else if (ev_lap) begin
          lap_idx_d = (lap_idx_q == oldest) ? newest : lap_idx_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      btn_q       <= '0;
      wr_ptr_q    <= '0;
      lap_idx_q   <= '0;
      lap_count_q <= '0;
      count_clr_q <= 1'b0;
      display_q   <= '0;
    end else begin
      state_q     <= state_d;
      btn_q       <= stimulus;
      wr_ptr_q    <= wr_ptr_d;
      lap_idx_q   <= lap_idx_d;
      lap_count_q <= lap_count_d;
      count_clr_q <= count_clr_d;
      display_q   <= (state_q == S_RETRIEVE) ? lap_mem[lap_idx_q] : time_in;
    end
  end

  // Lap storage is intentionally left uninitialised by reset
  always_ff @(posedge clock) begin
    if (lap_we) lap_mem[wr_ptr_q] <= time_in;
  end

  assign state       = state_q;
  assign count_en    = (state_q == S_RUN);
  assign showing_lap = (state_q == S_RETRIEVE);
  assign count_clr   = count_clr_q;
  assign lap_idx     = lap_idx_q;
  assign lap_count   = lap_count_q;
  assign display     = display_q;

endmodule
`default_nettype wire
